// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter
// Brief    : Shares the single data-memory port between the CPU M-stage and a
//            secondary master (DMA/debug loader). One outstanding access,
//            read latency timed by a down-counter, read data routed back to
//            the owner, pipeline stalled while the CPU waits.
// Config   : DM_ARB_RR_EN -- when defined, contention in IDLE is resolved
//            round-robin (master not granted last wins); otherwise fixed
//            CPU priority.
// Revision : 1.0 - initial release
// ============================================================================
module dm_port_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_byteen,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } state_t;

  // Counter load on read issue: completion happens when it reaches zero,
  // RD_LAT cycles after the issue cycle.
  localparam logic [2:0] C_CNT_INIT  = 3'(RD_LAT - 1);
  localparam logic       C_OWNER_CPU = 1'b0;
  localparam logic       C_OWNER_DMA = 1'b1;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        r_owner, w_owner_nxt;
  logic [31:0] r_addr, w_addr_nxt;

  logic        w_grant_cpu;
  logic        w_grant_dma;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_byteen;
  logic        w_rd_done;

`ifdef DM_ARB_RR_EN
  logic        r_last_grant, w_last_grant_nxt;

  // Round-robin winner: on contention the master not served last time wins;
  // a sole requester always wins.
  assign w_grant_dma = dma_req & (~cpu_req | (r_last_grant == C_OWNER_CPU));
  assign w_grant_cpu = cpu_req & ~w_grant_dma;
`else
  // Fixed priority: CPU always wins on contention.
  assign w_grant_cpu = cpu_req;
  assign w_grant_dma = dma_req & ~cpu_req;
`endif

  // Winner field mux (only meaningful when one of the grants is set).
  assign w_sel_we     = w_grant_cpu ? cpu_we     : dma_we;
  assign w_sel_addr   = w_grant_cpu ? cpu_addr   : dma_addr;
  assign w_sel_wdata  = w_grant_cpu ? cpu_wdata  : dma_wdata;
  assign w_sel_byteen = w_grant_cpu ? cpu_byteen : dma_byteen;

  assign w_rd_done    = (r_state == S_RD_WAIT) && (r_cnt == 3'd0);

  // State, latency counter, owner and latched address registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_owner <= C_OWNER_CPU;
      r_addr  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_owner <= w_owner_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

`ifdef DM_ARB_RR_EN
  // Remembers which master was issued last; reset points at the CPU.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= C_OWNER_CPU;
    end else begin
      r_last_grant <= w_last_grant_nxt;
    end
  end
`endif

  // Next-state and all outputs; outputs are forced to zero while reset is
  // asserted so a pending request cannot reach the memory during reset.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_owner_nxt = r_owner;
    w_addr_nxt  = r_addr;
`ifdef DM_ARB_RR_EN
    w_last_grant_nxt = r_last_grant;
`endif
    cpu_stall   = 1'b0;
    cpu_rvalid  = 1'b0;
    cpu_rdata   = 32'd0;
    dma_gnt     = 1'b0;
    dma_rvalid  = 1'b0;
    dma_rdata   = 32'd0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    mem_byteen  = 4'd0;

    if (reset_n) begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_cpu || w_grant_dma) begin
            mem_en     = 1'b1;
            mem_we     = w_sel_we;
            mem_addr   = w_sel_addr;
            mem_wdata  = w_sel_wdata;
            mem_byteen = w_sel_we ? w_sel_byteen : 4'd0;
            dma_gnt    = w_grant_dma;
`ifdef DM_ARB_RR_EN
            w_last_grant_nxt = w_grant_dma ? C_OWNER_DMA : C_OWNER_CPU;
`endif
            if (!w_sel_we) begin
              w_state_nxt = S_RD_WAIT;
              w_cnt_nxt   = C_CNT_INIT;
              w_owner_nxt = w_grant_dma ? C_OWNER_DMA : C_OWNER_CPU;
              w_addr_nxt  = w_sel_addr;
            end
          end
          // A CPU write finishes in its issue cycle; anything else stalls.
          cpu_stall = cpu_req & ~(w_grant_cpu & cpu_we);
        end

        S_RD_WAIT: begin
          mem_addr = r_addr;
          if (w_rd_done) begin
            if (r_owner == C_OWNER_DMA) begin
              dma_rvalid = 1'b1;
              dma_rdata  = mem_rdata;
            end else begin
              cpu_rvalid = 1'b1;
              cpu_rdata  = mem_rdata;
            end
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
          cpu_stall = cpu_req & ~(w_rd_done & (r_owner == C_OWNER_CPU));
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_port_arbiter
// Brief    : Self-checking bench for dm_port_arbiter. Directed scenarios then
//            randomized traffic from both masters, compared every cycle with
//            a transaction-level reference (completion cycle arithmetic and a
//            reference word memory).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

  localparam int LAT = 2;

  logic        clk;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic [3:0]  dma_byteen;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;

  dm_port_arbiter #(.RD_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_byteen(cpu_byteen),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_byteen(dma_byteen),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byteen(mem_byteen), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int          cyc = 0;
  bit          m_busy = 0;
  bit          m_owner = 0;      // 0 = CPU, 1 = DMA
  logic [31:0] m_addr = '0;
  int          m_done = 0;       // cycle in which the read completes
  logic [31:0] m_rdata = '0;
  bit          m_last = 0;       // last master issued (0 = CPU)
  logic [31:0] ref_mem [16];

  // Memory environment driven from the DUT bus
  logic [31:0] env_mem [16];
  bit          pipe_v [LAT];
  logic [31:0] pipe_d [LAT];

  // Expected / observed values of the current cycle
  logic        e_stall, e_crv, e_drv, e_gnt, e_en, e_we;
  logic [31:0] e_crd, e_drd, e_addr, e_wdata;
  logic [3:0]  e_be;
  logic        obs_stall, obs_crv, obs_drv, obs_gnt, obs_en, obs_we;
  logic [31:0] obs_crd, obs_drd, obs_addr;
  logic [3:0]  obs_be;
  bit          win_cpu, win_dma, last_cpu_done, last_dma_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: predict, compare at negedge, then advance model and
  // memory environment at the following posedge.
  task automatic step();
    logic        s_en, s_we, sel_we;
    logic [31:0] s_addr, s_wdata, sel_addr, sel_wdata;
    logic [3:0]  s_be, sel_be;
    @(negedge clk);
    {e_stall, e_crv, e_drv, e_gnt, e_en, e_we} = '0;
    e_crd = '0; e_drd = '0; e_addr = '0; e_wdata = '0; e_be = '0;
    win_cpu = 0; win_dma = 0;
    sel_we = 0; sel_addr = '0; sel_wdata = '0; sel_be = '0;
    if (reset_n) begin
      if (m_busy) begin
        e_addr = m_addr;
        if (cyc == m_done) begin
          if (m_owner) begin e_drv = 1; e_drd = m_rdata; end
          else begin e_crv = 1; e_crd = m_rdata; end
        end
        e_stall = cpu_req & ~e_crv;
      end else begin
        if (cpu_req && dma_req) begin
`ifdef DM_ARB_RR_EN
          win_dma = (m_last == 1'b0);
`else
          win_dma = 0;
`endif
          win_cpu = !win_dma;
        end else begin
          win_cpu = cpu_req;
          win_dma = dma_req;
        end
        if (win_cpu || win_dma) begin
          sel_we    = win_cpu ? cpu_we : dma_we;
          sel_addr  = win_cpu ? cpu_addr : dma_addr;
          sel_wdata = win_cpu ? cpu_wdata : dma_wdata;
          sel_be    = win_cpu ? cpu_byteen : dma_byteen;
          e_en = 1; e_we = sel_we; e_addr = sel_addr; e_wdata = sel_wdata;
          e_be = sel_we ? sel_be : 4'd0;
          e_gnt = win_dma;
        end
        e_stall = cpu_req & ~(win_cpu & cpu_we);
      end
    end
    check("cpu_stall",  cpu_stall,  e_stall);
    check("cpu_rvalid", cpu_rvalid, e_crv);
    check("cpu_rdata",  cpu_rdata,  e_crd);
    check("dma_gnt",    dma_gnt,    e_gnt);
    check("dma_rvalid", dma_rvalid, e_drv);
    check("dma_rdata",  dma_rdata,  e_drd);
    check("mem_en",     mem_en,     e_en);
    check("mem_we",     mem_we,     e_we);
    check("mem_addr",   mem_addr,   e_addr);
    check("mem_byteen", mem_byteen, e_be);
    if (e_en) check("mem_wdata", mem_wdata, e_wdata);
    obs_stall = cpu_stall; obs_crv = cpu_rvalid; obs_crd = cpu_rdata;
    obs_drv = dma_rvalid; obs_drd = dma_rdata; obs_gnt = dma_gnt;
    obs_en = mem_en; obs_we = mem_we; obs_addr = mem_addr; obs_be = mem_byteen;
    s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata; s_be = mem_byteen;
    last_cpu_done = reset_n && ((win_cpu && cpu_we) || e_crv);
    last_dma_gnt  = e_gnt;
    @(posedge clk);
    if (!reset_n) begin
      m_busy = 0; m_last = 0;
    end else if (m_busy) begin
      if (cyc == m_done) m_busy = 0;
    end else if (win_cpu || win_dma) begin
      m_last = win_dma;
      if (sel_we) ref_mem[sel_addr[5:2]] = merge_bytes(ref_mem[sel_addr[5:2]], sel_wdata, sel_be);
      else begin
        m_busy = 1; m_owner = win_dma; m_addr = sel_addr;
        m_done = cyc + LAT; m_rdata = ref_mem[sel_addr[5:2]];
      end
    end
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1]; pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[0] = s_en && !s_we;
    pipe_d[0] = env_mem[s_addr[5:2]];
    if (s_en && s_we) env_mem[s_addr[5:2]] = merge_bytes(env_mem[s_addr[5:2]], s_wdata, s_be);
    mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : $urandom;
    cyc++;
    #1;
  endtask

  // Masters drop a request once it has been served.
  task automatic retire();
    if (last_cpu_done) cpu_req = 0;
    if (last_dma_gnt)  dma_req = 0;
  endtask

  int gnt_at;
  bit rv_seen;

  initial begin
    reset_n = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_byteen = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_byteen = '0;
    mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; env_mem[i] = '0; end
    for (int i = 0; i < LAT; i++) begin pipe_v[i] = 0; pipe_d[i] = '0; end

    // Reset with a pending CPU write: nothing may reach the memory.
    step();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hFFFF_FFFF; cpu_byteen = 4'hF;
    step();
    check("rst_mem_en", obs_en, 1'b0);
    check("rst_stall",  obs_stall, 1'b0);
    cpu_req = 0;
    reset_n = 1;

    // DMA write 0xCAFEF00D @0x20
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hCAFE_F00D; dma_byteen = 4'hF;
    step();
    check("dw_gnt", obs_gnt, 1'b1);
    retire();

    // CPU store 0x12345678 @0x10, full word
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h1234_5678; cpu_byteen = 4'hF;
    step();
    check("t1_mem_en", obs_en, 1'b1);
    check("t1_mem_we", obs_we, 1'b1);
    check("t1_byteen", obs_be, 4'hF);
    check("t1_stall",  obs_stall, 1'b0);
    retire();

    // CPU load @0x10: two stall cycles then data
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    step(); check("t2_stall_c1", obs_stall, 1'b1);
    step(); check("t2_stall_c2", obs_stall, 1'b1);
    step();
    check("t2_rvalid", obs_crv, 1'b1);
    check("t2_rdata",  obs_crd, 32'h1234_5678);
    check("t2_stall_c3", obs_stall, 1'b0);
    retire();
    step();

    // Simultaneous reads: arbitration order visible in dma_gnt timing
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    dma_req = 1; dma_we = 0; dma_addr = 32'h20;
    gnt_at = -1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (obs_gnt && gnt_at < 0) gnt_at = k;
      retire();
    end
`ifdef DM_ARB_RR_EN
    check("t4_dma_gnt_cycle", gnt_at, 32'd0);
`else
    check("t3_dma_gnt_cycle", gnt_at, 32'd3);
`endif

    // Reset one cycle into RD_WAIT discards the read
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    step();
    reset_n = 0; cpu_req = 0;
    step();
    check("t5_stall", obs_stall, 1'b0);
    check("t5_addr",  obs_addr, 32'd0);
    check("t5_en",    obs_en, 1'b0);
    reset_n = 1;
    rv_seen = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      rv_seen = rv_seen | obs_crv | obs_drv;
    end
    check("t5_no_rvalid", rv_seen, 1'b0);

    // DMA write arriving during a CPU read waits for the first IDLE cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    step();
    dma_req = 1; dma_we = 1; dma_addr = 32'h24; dma_wdata = 32'h0BAD_F00D; dma_byteen = 4'b0011;
    gnt_at = -1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (obs_gnt && gnt_at < 0) gnt_at = k;
      retire();
    end
    check("t6_dma_gnt_cycle", gnt_at, 32'd2);

    // Randomized traffic from both masters
    for (int i = 0; i < 800; i++) begin
      retire();
      if (!cpu_req && !(m_busy && m_owner == 1'b0) && $urandom_range(0, 9) < 4) begin
        cpu_req = 1; cpu_we = 1'($urandom);
        cpu_addr = {26'd0, 4'($urandom), 2'b00};
        cpu_wdata = $urandom; cpu_byteen = 4'($urandom_range(1, 15));
      end else if (cpu_req && m_busy && m_owner == 1'b0 && $urandom_range(0, 9) < 2) begin
        cpu_req = 0;
      end
      if (!dma_req && $urandom_range(0, 9) < 4) begin
        dma_req = 1; dma_we = 1'($urandom);
        dma_addr = {26'd0, 4'($urandom), 2'b00};
        dma_wdata = $urandom; dma_byteen = 4'($urandom_range(1, 15));
      end
      reset_n = (i % 150 == 77) ? 1'b0 : 1'b1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
